// File: rtl/simple_uart_tx.sv
// Memory-mapped UART transmitter: register bus, byte FIFO and 8N1 serializer.
// One start bit, eight data bits LSB first, one stop bit, DIV clocks per bit.
module simple_uart_tx #(
    parameter int unsigned FifoDepth  = 8,
    parameter int unsigned DefaultDiv = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int unsigned AW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [15:0]   div_q;
    logic          tx_en_q;
    logic          irq_en_q;

    logic [7:0]    mem [FifoDepth];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q;
    logic          full, empty;
    logic          push, push_req, push_err;
    logic          load;

    logic [15:0]   cnt_q;
    logic [15:0]   divl_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          busy;

    logic          sel_tx, sel_st, sel_div, sel_ctrl;
    logic          wr, rd;
    logic [15:0]   div_wr;
    logic [31:0]   rd_val;

    logic          unused_bits;
    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:16], be_i[3:2]};

    assign sel_tx   = (addr_i[3:2] == 2'd0);
    assign sel_st   = (addr_i[3:2] == 2'd1);
    assign sel_div  = (addr_i[3:2] == 2'd2);
    assign sel_ctrl = (addr_i[3:2] == 2'd3);
    assign wr       = req_i & we_i;
    assign rd       = req_i & ~we_i;

    // Full is taken before any same-cycle pop, so a push into a full FIFO is rejected.
    assign full     = (level_q == LW'(FifoDepth));
    assign empty    = (level_q == '0);
    assign push_req = wr & sel_tx & be_i[0];
    assign push     = push_req & ~full;
    assign push_err = push_req & full;

    assign div_wr = {be_i[1] ? wdata_i[15:8] : div_q[15:8],
                     be_i[0] ? wdata_i[7:0]  : div_q[7:0]};

    // Configuration registers; a zero divisor is stored as one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q    <= 16'(DefaultDiv);
            tx_en_q  <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            if (wr && sel_div && (be_i[1] || be_i[0])) begin
                div_q <= (div_wr == 16'd0) ? 16'd1 : div_wr;
            end
            if (wr && sel_ctrl && be_i[0]) begin
                tx_en_q  <= wdata_i[0];
                irq_en_q <= wdata_i[1];
            end
        end
    end

    // FIFO storage needs no reset; validity is tracked by the level.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr_q] <= wdata_i[7:0];
        end
    end

    // FIFO pointers wrap by natural overflow since the depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (load) begin
                rptr_q <= rptr_q + AW'(1);
            end
            unique case ({push, load})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; load pops the head and starts a new frame.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx_en_q && !empty) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == 16'd0) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q == 16'd0 && bit_q == 3'd7) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == 16'd0) begin
                    if (tx_en_q && !empty) begin
                        load    = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit timer and shifter; the divisor is latched per frame so DIV writes
    // take effect only on the following frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            divl_q  <= 16'd1;
            bit_q   <= '0;
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= mem[rptr_q];
            divl_q  <= div_q;
            cnt_q   <= div_q - 16'd1;
            bit_q   <= '0;
        end else if (state_q != IDLE) begin
            if (cnt_q == 16'd0) begin
                cnt_q <= divl_q - 16'd1;
                if (state_q == DATA) begin
                    shreg_q <= {1'b0, shreg_q[7:1]};
                    bit_q   <= bit_q + 3'd1;
                end
            end else begin
                cnt_q <= cnt_q - 16'd1;
            end
        end
    end

    // FSM outputs: line level and busy flag.
    always_comb begin
        busy = (state_q != IDLE);
        tx_o = 1'b1;
        unique case (state_q)
            START:   tx_o = 1'b0;
            DATA:    tx_o = shreg_q[0];
            default: tx_o = 1'b1;
        endcase
    end

    // Read data mux for the register map.
    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_st:   rd_val = {22'd0, 7'(level_q), busy, empty, full};
            sel_div:  rd_val = {16'd0, div_q};
            sel_ctrl: rd_val = {30'd0, irq_en_q, tx_en_q};
            default:  rd_val = '0;
        endcase
    end

    // Single-cycle bus response and registered interrupt.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= rd ? rd_val : 32'd0;
            err_o    <= push_err;
            irq_o    <= irq_en_q & empty & ~busy;
        end
    end

endmodule

// File: tb/tb_simple_uart_tx.sv
// Directed bench for simple_uart_tx: register access, frame timing,
// FIFO full/back-to-back, interrupt, divisor handling and mid-frame reset.
module tb_simple_uart_tx;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        tx;
    logic        irq;

    int n_cmp;
    int n_err;

    logic [7:0] q_bytes [8];

    simple_uart_tx #(
        .FifoDepth (8),
        .DefaultDiv(16)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req),
        .we_i    (we),
        .be_i    (be),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rvalid_o(rvalid),
        .rdata_o (rdata),
        .err_o   (err),
        .tx_o    (tx),
        .irq_o   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level at cycle i of a frame carrying b with divisor d.
    function automatic logic exp_tx(input logic [7:0] b, input int d, input int i);
        int s;
        s = i / d;
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
        return 1'b1;
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, output logic e,
                             output logic [31:0] r, output logic v);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
        @(negedge clk);
        v = rvalid; e = err; r = rdata;
        req = 1'b0; we = 1'b0; be = 4'h0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] r,
                            output logic v, output logic e);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a; be = 4'hf;
        @(negedge clk);
        v = rvalid; e = err; r = rdata;
        req = 1'b0; be = 4'h0;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        logic v, e;
        #12;
        n_cmp++;
        if ({tx, rvalid, err, irq} !== 4'b1000 || rdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: tx/rvalid/err/irq=%b rdata=%h, want 1000 / 0",
                     {tx, rvalid, err, irq}, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(32'h4, r, v, e);
        n_cmp++;
        if (v !== 1'b1 || r !== 32'h2) begin
            n_err++;
            $display("FAIL reset_status: rvalid=%b data=%h, want 1 / 00000002", v, r);
        end
        bus_read(32'h8, r, v, e);
        n_cmp++;
        if (r !== 32'd16) begin
            n_err++;
            $display("FAIL reset_div: got %h, want 00000010", r);
        end
        bus_read(32'hC, r, v, e);
        n_cmp++;
        if (r !== 32'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %h, want 0", r);
        end
    endtask

    task automatic test_regs;
        logic [31:0] r;
        logic v, e;
        bus_write(32'h4, 32'hFFFF_FFFF, 4'hf, e, r, v);
        n_cmp++;
        if (v !== 1'b1 || e !== 1'b0 || r !== 32'd0) begin
            n_err++;
            $display("FAIL status_write: rvalid=%b err=%b rdata=%h, want 1 0 0", v, e, r);
        end
        @(negedge clk);
        n_cmp++;
        if (rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rvalid_pulse: rvalid=%b, want 0", rvalid);
        end
        bus_read(32'h4, r, v, e);
        n_cmp++;
        if (r !== 32'h2) begin
            n_err++;
            $display("FAIL status_ro: got %h, want 00000002", r);
        end
        bus_write(32'h8, 32'h0000_AB07, 4'b0010, e, r, v);
        bus_read(32'h8, r, v, e);
        n_cmp++;
        if (r !== 32'h0000_AB10) begin
            n_err++;
            $display("FAIL div_byte_en: got %h, want 0000ab10", r);
        end
        bus_read(32'h0, r, v, e);
        n_cmp++;
        if (r !== 32'd0) begin
            n_err++;
            $display("FAIL txdata_read: got %h, want 0", r);
        end
        bus_write(32'hC, 32'h3, 4'b0010, e, r, v);
        bus_read(32'hC, r, v, e);
        n_cmp++;
        if (r !== 32'd0) begin
            n_err++;
            $display("FAIL ctrl_byte_en: got %h, want 0", r);
        end
    endtask

    task automatic test_basic_frame;
        logic [31:0] r;
        logic v, e;
        int bad;
        bus_write(32'h8, 32'd4, 4'hf, e, r, v);
        bus_write(32'hC, 32'h1, 4'hf, e, r, v);
        bus_write(32'h0, 32'hA5, 4'h1, e, r, v);
        n_cmp++;
        if (e !== 1'b0 || tx !== 1'b1) begin
            n_err++;
            $display("FAIL push_latency: err=%b tx=%b, want 0 1", e, tx);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx !== exp_tx(8'hA5, 4, i)) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL frame_a5: %0d wrong cycles, want 0", bad);
        end
        @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL frame_a5_end: tx=%b, want 1", tx);
        end
    endtask

    task automatic test_fifo_full;
        logic [31:0] r;
        logic v, e;
        int bad;
        bus_write(32'hC, 32'h0, 4'hf, e, r, v);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            bus_write(32'h0, {24'd0, q_bytes[k]}, 4'h1, e, r, v);
            if (e !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL fill_err: %0d pushes errored, want 0", bad);
        end
        bus_write(32'h0, 32'hEE, 4'h1, e, r, v);
        n_cmp++;
        if (e !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_err: err=%b, want 1", e);
        end
        bus_read(32'h4, r, v, e);
        n_cmp++;
        if (r !== 32'h41) begin
            n_err++;
            $display("FAIL full_status: got %h, want 00000041", r);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        logic v, e;
        int bad;
        bus_write(32'hC, 32'h1, 4'hf, e, r, v);
        bad = 0;
        for (int i = 0; i < 320; i++) begin
            @(negedge clk);
            if (tx !== exp_tx(q_bytes[i/40], 4, i % 40)) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL b2b_frames: %0d wrong cycles, want 0", bad);
        end
        @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_end: tx=%b, want 1", tx);
        end
        bus_read(32'h4, r, v, e);
        n_cmp++;
        if (r !== 32'h2) begin
            n_err++;
            $display("FAIL b2b_status: got %h, want 00000002", r);
        end
    endtask

    task automatic test_irq;
        logic [31:0] r;
        logic v, e;
        int bad;
        bus_write(32'hC, 32'h3, 4'hf, e, r, v);
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL irq_idle: irq=%b, want 1", irq);
        end
        bus_write(32'h0, 32'hFF, 4'h1, e, r, v);
        bad = 0;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (irq !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL irq_busy: %0d cycles high, want 0", bad);
        end
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL irq_done: irq=%b, want 1", irq);
        end
        bus_write(32'hC, 32'h1, 4'hf, e, r, v);
    endtask

    task automatic test_div;
        logic [31:0] r;
        logic v, e;
        int bad;
        bus_write(32'h8, 32'h0, 4'hf, e, r, v);
        bus_read(32'h8, r, v, e);
        n_cmp++;
        if (r !== 32'd1) begin
            n_err++;
            $display("FAIL div_zero: got %h, want 00000001", r);
        end
        bus_write(32'h8, 32'd4, 4'hf, e, r, v);
        bus_write(32'h0, 32'h3C, 4'h1, e, r, v);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx !== exp_tx(8'h3C, 4, i)) bad++;
            if (i == 10) begin
                req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'd8; be = 4'hf;
            end
            if (i == 11) begin
                req = 1'b0; we = 1'b0; be = 4'h0; wdata = '0;
            end
        end
        @(negedge clk);
        if (tx !== 1'b1) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL div_midframe: %0d wrong cycles, want 0", bad);
        end
        bus_read(32'h8, r, v, e);
        n_cmp++;
        if (r !== 32'd8) begin
            n_err++;
            $display("FAIL div_readback: got %h, want 00000008", r);
        end
        bus_write(32'h0, 32'hC3, 4'h1, e, r, v);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx !== exp_tx(8'hC3, 8, i)) bad++;
        end
        @(negedge clk);
        if (tx !== 1'b1) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL div8_frame: %0d wrong cycles, want 0", bad);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r;
        logic v, e;
        bus_write(32'h8, 32'd4, 4'hf, e, r, v);
        bus_write(32'h0, 32'h00, 4'h1, e, r, v);
        bus_write(32'h0, 32'h55, 4'h1, e, r, v);
        bus_read(32'h4, r, v, e);
        n_cmp++;
        if (r !== 32'h0C) begin
            n_err++;
            $display("FAIL push_pop_level: got %h, want 0000000c", r);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b0) begin
            n_err++;
            $display("FAIL in_data: tx=%b, want 0", tx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tx !== 1'b1 || irq !== 1'b0 || rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: tx=%b irq=%b rvalid=%b, want 1 0 0", tx, irq, rvalid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(32'h4, r, v, e);
        n_cmp++;
        if (r !== 32'h2) begin
            n_err++;
            $display("FAIL post_reset_status: got %h, want 00000002", r);
        end
        bus_read(32'h8, r, v, e);
        n_cmp++;
        if (r !== 32'd16) begin
            n_err++;
            $display("FAIL post_reset_div: got %h, want 00000010", r);
        end
        bus_read(32'hC, r, v, e);
        n_cmp++;
        if (r !== 32'd0) begin
            n_err++;
            $display("FAIL post_reset_ctrl: got %h, want 0", r);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        q_bytes = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h7E, 8'h96};
        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        be    = 4'h0;
        addr  = '0;
        wdata = '0;
        test_reset;
        test_regs;
        test_basic_frame;
        test_fifo_full;
        test_back_to_back;
        test_irq;
        test_div;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/simple_uart_tx.md
SIMPLE_UART_TX -- requirements
Module: simple_uart_tx

Interface
REQ-001 SHALL have parameter FifoDepth, default 8, meaning TX FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter DefaultDiv, default 16, meaning reset value of the DIV register (clock cycles per bit).
REQ-003 SHALL have port clk_i, input, 1, the single system clock.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_i, input, 1, bus device request.
REQ-006 SHALL have port we_i, input, 1, write enable.
REQ-007 SHALL have port be_i, input, 4, byte enables.
REQ-008 SHALL have port addr_i, input, 32, byte address; only addr_i[3:2] is decoded.
REQ-009 SHALL have port wdata_i, input, 32, write data.
REQ-010 SHALL have port rvalid_o, output, 1, response valid.
REQ-011 SHALL have port rdata_o, output, 32, read data.
REQ-012 SHALL have port err_o, output, 1, response error, qualified by rvalid_o.
REQ-013 SHALL have port tx_o, output, 1, serial line, idle high.
REQ-014 SHALL have port irq_o, output, 1, level TX-done interrupt.

Function
REQ-015 SHALL accept every request in the cycle req_i is high (no stall); rvalid_o SHALL assert for exactly one cycle, one cycle after req_i.
REQ-016 SHALL drive rdata_o with read data together with rvalid_o; it SHALL be 0 for writes and when rvalid_o is low.
REQ-017 SHALL decode this register map:
- 0x0 TXDATA: write pushes wdata_i[7:0] when be_i[0]=1; reads return 0.
- 0x4 STATUS (RO): [0] full, [1] empty, [2] busy, [9:3] FIFO level.
- 0x8 DIV (RW): [15:0].
- 0xC CTRL (RW): [0] tx_en, [1] irq_en.
REQ-018 SHALL ignore writes to STATUS without error; be_i[1:0] SHALL gate DIV bytes, and be_i[0] SHALL gate CTRL.
REQ-019 SHALL store a DIV write of 0 as 1.
REQ-020 SHALL, on a TXDATA push while full, drop the byte and assert err_o with that response. Full is evaluated before any same-cycle pop, so the push is rejected even if a pop occurs in that cycle.
REQ-021 SHALL allow a push and a pop in the same cycle when not full; level is then unchanged.
REQ-022 SHALL implement FSM IDLE, START, DATA, STOP:
- IDLE: when tx_en=1 and the FIFO is non-empty, pop the head and latch DIV into the bit counter; go to START.
- START: tx_o=0 for DIV cycles, then go to DATA.
- DATA: 8 bits LSB first, DIV cycles each, then go to STOP.
- STOP: tx_o=1 for DIV cycles. Then, if tx_en=1 and the FIFO is non-empty, pop and go directly to START (back-to-back); otherwise go to IDLE.
REQ-023 SHALL make a frame occupy exactly 10*DIV cycles; a DIV write mid-frame SHALL apply from the next frame.
REQ-024 SHALL, for a push at edge E0 into an empty FIFO with the FSM in IDLE and tx_en=1, pop at E1; tx_o SHALL go low after E1.
REQ-025 SHALL, when tx_en is cleared mid-frame, complete the current frame and then hold in IDLE.
REQ-026 SHALL drive busy=1 whenever the state is not IDLE.
REQ-027 SHALL drive irq_o = irq_en & empty & ~busy, registered.
REQ-028 SHALL wrap the FIFO read and write pointers modulo FifoDepth; level SHALL range 0..FifoDepth.

Reset
REQ-029 SHALL, while rst_ni=0, asynchronously force:
- tx_o=1, rvalid_o=0, rdata_o=0, err_o=0, irq_o=0;
- FSM state IDLE, FIFO empty;
- DIV=DefaultDiv, CTRL=0.
REQ-030 SHALL abort any in-flight frame on reset; the FIFO contents are lost and tx_o returns high immediately.

Verification
REQ-031 SHALL cover: write CTRL=1, DIV=4, TXDATA=0xA5 -> tx_o low 4 cycles, then bits 1,0,1,0,0,1,0,1 of 4 cycles each, then high 4 cycles; total 40 cycles.
REQ-032 SHALL cover: tx_en=0, push 8 bytes, then a 9th -> 9th response err_o=1; STATUS reads full=1, level=8.
REQ-033 SHALL cover: then set tx_en=1 -> 8 frames back-to-back with no idle gap (80*DIV cycles); afterwards STATUS empty=1, busy=0.
REQ-034 SHALL cover: irq_en=1, send one byte -> irq_o=0 while busy, then 1 one cycle after IDLE is reached.
REQ-035 SHALL cover: write DIV=0 -> DIV reads back 1; a DIV change mid-frame leaves the current frame length unchanged.
REQ-036 SHALL cover: assert rst_ni mid-DATA -> tx_o=1 asynchronously; after release, STATUS reads empty=1 and DIV reads 16.
